// File: rtl/pipe_hazard_pkg.sv
// Shared constants and helpers for the pipeline hazard controller.
// Hazard priority codes are plain localparams, so they can be seen directly in waveforms and checkers.
package pipe_hazard_pkg;

    localparam int REG_W         = 5;
    localparam int HZ_W          = 3;
    localparam int MD_CYCLES_DEF = 32;
    localparam int CNT_W_DEF     = 6;

    // Winning hazard source in the current cycle, listed from lowest to highest priority
    localparam logic [HZ_W-1:0] HZ_NONE    = 3'd0;
    localparam logic [HZ_W-1:0] HZ_LOADUSE = 3'd1;
    localparam logic [HZ_W-1:0] HZ_MDSTALL = 3'd2;
    localparam logic [HZ_W-1:0] HZ_BRFLUSH = 3'd3;
    localparam logic [HZ_W-1:0] HZ_MEMWAIT = 3'd4;

    typedef logic [REG_W-1:0] reg_num_t;
    typedef logic [HZ_W-1:0]  hz_code_t;

    // A load in EX feeds a source of the ID instruction. Register 0 is hardwired, so it never creates a hazard.
    function automatic logic load_use_hit(input logic     ex_memread,
                                          input reg_num_t ex_rt,
                                          input reg_num_t id_rs,
                                          input reg_num_t id_rt,
                                          input logic     id_uses_rt);
        return ex_memread && (ex_rt != '0) &&
               ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt)));
    endfunction

endpackage

// File: rtl/pipe_hazard_ctl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
//
// Data-memory handshake: mem_req is high while MEM holds an access. mem_ready is high in the
// cycle the memory completes that access. While mem_req=1 and mem_ready=0, the access is
// outstanding, and the whole front of the pipe is held.
// hz_code and md_cnt are debug views of the controller state.
interface pipe_hazard_ctl_if
    import pipe_hazard_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    reg_num_t         id_rs;
    reg_num_t         id_rt;
    logic             id_uses_rt;
    reg_num_t         ex_rt;
    logic             ex_memread;
    logic             ex_br_taken;
    logic             id_md_start;
    logic             id_md_read;
    logic             mem_req;
    logic             mem_ready;

    logic             stall_pc;
    logic             stall_d;
    logic             zero_d;
    logic             stall_e;
    logic             zero_e;
    logic             stall_m;
    logic             zero_m;
    logic             zero_w;
    logic             md_busy;
    logic             md_done;

    hz_code_t         hz_code;
    logic [CNT_W-1:0] md_cnt;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, ex_br_taken,
               id_md_start, id_md_read, mem_req, mem_ready,
        input  stall_pc, stall_d, zero_d, stall_e, zero_e, stall_m, zero_m, zero_w,
               md_busy, md_done, hz_code, md_cnt
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_rt, ex_memread, ex_br_taken,
               id_md_start, id_md_read, mem_req, mem_ready,
        output stall_pc, stall_d, zero_d, stall_e, zero_e, stall_m, zero_m, zero_w,
               md_busy, md_done, hz_code, md_cnt
    );

endinterface

// File: rtl/pipe_hazard_ctl_md_busy_ctr.sv
// Mult/div occupancy counter. It is loaded when a mult/div leaves ID and counts down to idle.
// The issue cycle itself is the first of the MD_CYCLES latency cycles, so the counter loads MD_CYCLES-1.
// A dependent mfhi/mflo therefore waits MD_CYCLES-1 cycles in ID.
module md_busy_ctr
    import pipe_hazard_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             issue,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] cnt
);

    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(MD_CYCLES - 1);

    // Load on issue, otherwise count down to zero. The counter keeps running while the pipe is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (issue) begin
            cnt <= LOAD_VAL;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Busy while counting. Done marks the last busy cycle (count 1 -> 0 on the next edge).
    always_comb begin
        busy = (cnt != '0);
        done = (cnt == CNT_W'(1));
    end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Pipeline hazard controller. It picks a single winning hazard source each cycle and turns it
// into stall/zero controls for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers.
// While reset is asserted, and for one cycle after it is released, every pipeline register is zeroed.
module pipe_hazard_ctl
    import pipe_hazard_pkg::*;
#(
    parameter int MD_CYCLES = MD_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pipe_hazard_ctl_if.slave     hz
);

    logic             post_rst;
    logic             flush_all;
    logic             mem_wait;
    logic             load_use;
    logic             md_stall;
    logic             md_issue;
    logic             md_busy_w;
    logic             md_done_w;
    logic [CNT_W-1:0] md_cnt_w;
    hz_code_t         hz_code;

    // Set by reset. Clears on the first edge after release, so the pipe is flushed for one extra cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            post_rst <= 1'b1;
        end else begin
            post_rst <= 1'b0;
        end
    end

    // Raw hazard sources, then a strict priority pick: memory wait > branch > mult/div > load-use.
    always_comb begin
        mem_wait = hz.mem_req && !hz.mem_ready;
        load_use = load_use_hit(hz.ex_memread, hz.ex_rt, hz.id_rs, hz.id_rt, hz.id_uses_rt);
        md_stall = md_busy_w && (hz.id_md_read || hz.id_md_start);
        if (mem_wait) begin
            hz_code = HZ_MEMWAIT;
        end else if (hz.ex_br_taken) begin
            hz_code = HZ_BRFLUSH;
        end else if (md_stall) begin
            hz_code = HZ_MDSTALL;
        end else if (load_use) begin
            hz_code = HZ_LOADUSE;
        end else begin
            hz_code = HZ_NONE;
        end
    end

    // A mult/div only issues when ID really advances, with no hazard and no reset flush.
    // A wrong-path op behind a taken branch is therefore never counted.
    always_comb begin
        flush_all = !rst_n || post_rst;
        md_issue  = !flush_all && (hz_code == HZ_NONE) && hz.id_md_start;
    end

    md_busy_ctr #(
        .MD_CYCLES (MD_CYCLES),
        .CNT_W     (CNT_W)
    ) u_md_busy_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .issue (md_issue),
        .busy  (md_busy_w),
        .done  (md_done_w),
        .cnt   (md_cnt_w)
    );

    // Map the winning hazard onto register controls. The reset flush overrides everything.
    always_comb begin
        hz.stall_pc = 1'b0;
        hz.stall_d  = 1'b0;
        hz.zero_d   = 1'b0;
        hz.stall_e  = 1'b0;
        hz.zero_e   = 1'b0;
        hz.stall_m  = 1'b0;
        hz.zero_m   = 1'b0;
        hz.zero_w   = 1'b0;
        if (flush_all) begin
            hz.zero_d = 1'b1;
            hz.zero_e = 1'b1;
            hz.zero_m = 1'b1;
            hz.zero_w = 1'b1;
        end else begin
            case (hz_code)
                HZ_MEMWAIT: begin
                    // Hold everything up to EX/MEM. MEM/WB drains with a bubble.
                    hz.stall_pc = 1'b1;
                    hz.stall_d  = 1'b1;
                    hz.stall_e  = 1'b1;
                    hz.stall_m  = 1'b1;
                    hz.zero_w   = 1'b1;
                end
                HZ_BRFLUSH: begin
                    // Squash the two wrong-path instructions in IF/ID and ID/EX.
                    hz.zero_d = 1'b1;
                    hz.zero_e = 1'b1;
                end
                HZ_MDSTALL, HZ_LOADUSE: begin
                    // Keep the instruction in ID and insert a bubble into EX.
                    hz.stall_pc = 1'b1;
                    hz.stall_d  = 1'b1;
                    hz.zero_e   = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Status and debug views of the controller state.
    always_comb begin
        hz.md_busy = md_busy_w;
        hz.md_done = md_done_w;
        hz.md_cnt  = md_cnt_w;
        hz.hz_code = hz_code;
    end

endmodule

// File: tb/tb_pipe_hazard_ctl.sv
// Bench for pipe_hazard_ctl.
// dut runs with a short mult/div latency (4) so the whole stall window can be walked cycle by cycle.
// dut2 uses the default latency (32) so reset can be asserted while the count is at 10.
module tb_pipe_hazard_ctl;
    import pipe_hazard_pkg::*;

    // Output vector layout, bit 9 down to bit 0:
    // {stall_pc, stall_d, stall_e, stall_m, zero_d, zero_e, zero_m, zero_w, md_busy, md_done}
    localparam logic [9:0] S_PC   = 10'b10_0000_0000;
    localparam logic [9:0] S_D    = 10'b01_0000_0000;
    localparam logic [9:0] S_E    = 10'b00_1000_0000;
    localparam logic [9:0] S_M    = 10'b00_0100_0000;
    localparam logic [9:0] Z_D    = 10'b00_0010_0000;
    localparam logic [9:0] Z_E    = 10'b00_0001_0000;
    localparam logic [9:0] Z_M    = 10'b00_0000_1000;
    localparam logic [9:0] Z_W    = 10'b00_0000_0100;
    localparam logic [9:0] BUSY   = 10'b00_0000_0010;
    localparam logic [9:0] DONE   = 10'b00_0000_0001;
    localparam logic [9:0] O_NONE = 10'b0;
    localparam logic [9:0] O_LU   = S_PC | S_D | Z_E;
    localparam logic [9:0] O_BR   = Z_D | Z_E;
    localparam logic [9:0] O_MW   = S_PC | S_D | S_E | S_M | Z_W;
    localparam logic [9:0] O_ZALL = Z_D | Z_E | Z_M | Z_W;

    typedef struct packed {
        logic       memread;
        logic [4:0] ex_rt;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       uses_rt;
        logic       br;
        logic       md_start;
        logic       md_read;
        logic       mem_req;
        logic       mem_ready;
    } stim_t;

    logic clk = 1'b0;
    logic rst_n;
    logic rst2_n;

    logic [9:0] exp_q[$];
    int         checks = 0;
    int         errors = 0;

    pipe_hazard_ctl_if #(.CNT_W(6)) bus ();
    pipe_hazard_ctl_if #(.CNT_W(6)) bus2 ();

    pipe_hazard_ctl #(.MD_CYCLES(4), .CNT_W(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (bus.slave)
    );

    pipe_hazard_ctl #(.MD_CYCLES(32), .CNT_W(6)) dut2 (
        .clk   (clk),
        .rst_n (rst2_n),
        .hz    (bus2.slave)
    );

    logic [9:0] obs;
    logic [9:0] obs2;
    assign obs  = {bus.stall_pc, bus.stall_d, bus.stall_e, bus.stall_m, bus.zero_d,
                   bus.zero_e, bus.zero_m, bus.zero_w, bus.md_busy, bus.md_done};
    assign obs2 = {bus2.stall_pc, bus2.stall_d, bus2.stall_e, bus2.stall_m, bus2.zero_d,
                   bus2.zero_e, bus2.zero_m, bus2.zero_w, bus2.md_busy, bus2.md_done};

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got running, want finished");
        $fatal(1, "watchdog");
    end

    // ---------------- drivers ----------------
    function automatic stim_t st(input logic mr, input logic [4:0] ert, input logic [4:0] rs,
                                 input logic [4:0] rt, input logic ur, input logic br,
                                 input logic ms, input logic mrd, input logic mq, input logic mrdy);
        stim_t s;
        s = '{memread: mr, ex_rt: ert, id_rs: rs, id_rt: rt, uses_rt: ur, br: br,
              md_start: ms, md_read: mrd, mem_req: mq, mem_ready: mrdy};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        bus.ex_memread  = s.memread;
        bus.ex_rt       = s.ex_rt;
        bus.id_rs       = s.id_rs;
        bus.id_rt       = s.id_rt;
        bus.id_uses_rt  = s.uses_rt;
        bus.ex_br_taken = s.br;
        bus.id_md_start = s.md_start;
        bus.id_md_read  = s.md_read;
        bus.mem_req     = s.mem_req;
        bus.mem_ready   = s.mem_ready;
    endtask

    // Drive one cycle of stimulus and record the outputs it must produce.
    task automatic drive(input stim_t s, input logic [9:0] e);
        apply(s);
        exp_q.push_back(e);
    endtask

    task automatic idle2();
        bus2.ex_memread  = 1'b0;
        bus2.ex_rt       = '0;
        bus2.id_rs       = '0;
        bus2.id_rt       = '0;
        bus2.id_uses_rt  = 1'b0;
        bus2.ex_br_taken = 1'b0;
        bus2.id_md_start = 1'b0;
        bus2.id_md_read  = 1'b0;
        bus2.mem_req     = 1'b0;
        bus2.mem_ready   = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        logic [9:0] e;
        rst_n  = 1'b0;
        rst2_n = 1'b0;
        apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        idle2();
        for (int i = 0; i < 3; i++) begin
            // The second reset cycle also raises a memory wait; the reset flush must still win.
            if (i == 1) drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_ZALL);
            else        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_ZALL);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL reset_hold[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
        rst_n  = 1'b1;
        rst2_n = 1'b1;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_ZALL);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_post_cycle: got %b want %b", obs, e);
        end
        @(posedge clk); #1;
        drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs !== e) begin
            errors++;
            $display("FAIL reset_released: got %b want %b", obs, e);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_load_use();
        logic [9:0] e;
        logic [4:0] r;
        logic [4:0] r2;
        r  = 5'($urandom_range(1, 31));
        r2 = (r == 5'd31) ? 5'd1 : r + 5'd1;
        drive(st(1, 8, 8, 0, 0, 0, 0, 0, 0, 0), O_LU);      // load r8, ID reads r8
        drive(st(0, 8, 8, 0, 0, 0, 0, 0, 0, 0), O_NONE);    // load has left EX
        drive(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE);    // register 0 never hazards
        drive(st(1, 9, 3, 9, 1, 0, 0, 0, 0, 0), O_LU);      // match on rt
        drive(st(1, 9, 3, 9, 0, 0, 0, 0, 0, 0), O_NONE);    // rt not read
        drive(st(1, r, r, 0, 0, 0, 0, 0, 0, 0), O_LU);      // random register match on rs
        drive(st(1, r, r2, r2, 1, 0, 0, 0, 0, 0), O_NONE);  // random register, no match
        for (int i = 0; i < 7; i++) begin
            apply(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        end
        exp_q.delete();
        // Replay the table one cycle at a time, so each row is compared in its own cycle.
        begin
            stim_t rows[7];
            logic [9:0] exps[7];
            rows[0] = st(1, 8, 8, 0, 0, 0, 0, 0, 0, 0);   exps[0] = O_LU;
            rows[1] = st(0, 8, 8, 0, 0, 0, 0, 0, 0, 0);   exps[1] = O_NONE;
            rows[2] = st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);   exps[2] = O_NONE;
            rows[3] = st(1, 9, 3, 9, 1, 0, 0, 0, 0, 0);   exps[3] = O_LU;
            rows[4] = st(1, 9, 3, 9, 0, 0, 0, 0, 0, 0);   exps[4] = O_NONE;
            rows[5] = st(1, r, r, 0, 0, 0, 0, 0, 0, 0);   exps[5] = O_LU;
            rows[6] = st(1, r, r2, r2, 1, 0, 0, 0, 0, 0); exps[6] = O_NONE;
            for (int i = 0; i < 7; i++) begin
                drive(rows[i], exps[i]);
                @(negedge clk);
                e = exp_q.pop_front();
                checks++;
                if (obs !== e) begin
                    errors++;
                    $display("FAIL load_use[%0d]: got %b want %b", i, obs, e);
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic test_branch();
        logic [9:0] e;
        stim_t rows[4];
        logic [9:0] exps[4];
        rows[0] = st(1, 8, 8, 0, 0, 1, 0, 0, 0, 0); exps[0] = O_BR;     // branch beats load-use
        rows[1] = st(0, 0, 0, 0, 0, 1, 1, 0, 0, 0); exps[1] = O_BR;     // wrong-path mult in ID
        rows[2] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exps[2] = O_NONE;   // ...was never counted
        rows[3] = st(1, 8, 8, 0, 0, 1, 0, 0, 1, 0); exps[3] = O_MW;     // memory wait beats branch
        for (int i = 0; i < 4; i++) begin
            drive(rows[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL branch[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mult_div();
        logic [9:0] e;
        stim_t rows[19];
        logic [9:0] exps[19];
        // Issue, then mflo waits while the count is 3, 2, 1, then advances.
        rows[0]  = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exps[0]  = O_NONE;
        rows[1]  = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exps[1]  = O_LU | BUSY;
        rows[2]  = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exps[2]  = O_LU | BUSY;
        rows[3]  = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exps[3]  = O_LU | BUSY | DONE;
        rows[4]  = st(0, 0, 0, 0, 0, 0, 0, 1, 0, 0); exps[4]  = O_NONE;
        // Back-to-back: the second mult waits, then issues when the count reaches 0.
        rows[5]  = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exps[5]  = O_NONE;
        rows[6]  = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exps[6]  = O_LU | BUSY;
        rows[7]  = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exps[7]  = O_LU | BUSY;
        rows[8]  = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exps[8]  = O_LU | BUSY | DONE;
        rows[9]  = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exps[9]  = O_NONE;
        rows[10] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exps[10] = BUSY;
        rows[11] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exps[11] = BUSY;
        rows[12] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exps[12] = BUSY | DONE;
        rows[13] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exps[13] = O_NONE;
        // The count keeps running through a memory wait.
        rows[14] = st(0, 0, 0, 0, 0, 0, 1, 0, 0, 0); exps[14] = O_NONE;
        rows[15] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exps[15] = O_MW | BUSY;
        rows[16] = st(0, 0, 0, 0, 0, 0, 0, 0, 1, 0); exps[16] = O_MW | BUSY;
        rows[17] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exps[17] = BUSY | DONE;
        rows[18] = st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); exps[18] = O_NONE;
        for (int i = 0; i < 19; i++) begin
            drive(rows[i], exps[i]);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mult_div[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mem_wait();
        logic [9:0] e;
        for (int i = 0; i < 8; i++) begin
            if (i < 5)       drive(st(1, 8, 8, 0, 0, 0, 0, 0, 1, 0), O_MW);   // wait during load-use
            else if (i == 5) drive(st(1, 8, 8, 0, 0, 0, 0, 0, 1, 1), O_LU);   // completes, load-use applies
            else if (i == 6) drive(st(0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_NONE); // ready with request: no wait
            else             drive(st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0), O_NONE);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs !== e) begin
                errors++;
                $display("FAIL mem_wait[%0d]: got %b want %b", i, obs, e);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_md_reset();
        logic [9:0] e;
        bus2.id_md_start = 1'b1;
        @(posedge clk); #1;
        bus2.id_md_start = 1'b0;
        repeat (21) @(posedge clk);
        #1;
        // The count is now 10.
        exp_q.push_back(BUSY);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs2 !== e) begin
            errors++;
            $display("FAIL md_reset_before: got %b want %b", obs2, e);
        end
        #1;
        rst2_n = 1'b0;
        exp_q.push_back(O_ZALL);
        #1;
        e = exp_q.pop_front();
        checks++;
        if (obs2 !== e) begin
            errors++;
            $display("FAIL md_reset_immediate: got %b want %b", obs2, e);
        end
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(O_ZALL);
            @(negedge clk);
            e = exp_q.pop_front();
            checks++;
            if (obs2 !== e) begin
                errors++;
                $display("FAIL md_reset_hold[%0d]: got %b want %b", i, obs2, e);
            end
        end
        @(posedge clk); #1;
        rst2_n = 1'b1;
        exp_q.push_back(O_ZALL);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs2 !== e) begin
            errors++;
            $display("FAIL md_reset_post: got %b want %b", obs2, e);
        end
        @(posedge clk); #1;
        exp_q.push_back(O_NONE);
        @(negedge clk);
        e = exp_q.pop_front();
        checks++;
        if (obs2 !== e) begin
            errors++;
            $display("FAIL md_reset_idle: got %b want %b", obs2, e);
        end
        @(posedge clk); #1;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_load_use();
        test_branch();
        test_mult_div();
        test_mem_wait();
        test_md_reset();
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d entries left want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
